// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - SPI word-stream command decoder driving a single-port byte RAM
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic [ADDR_SIZE-1:0] wr_addr_q,
    output logic [ADDR_SIZE-1:0] rd_addr_q
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    logic [7:0]           mem [MEM_DEPTH];
    logic                 rx_valid_d_q;
    logic                 rx_valid_d_d;
    logic [ADDR_SIZE-1:0] wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_d;
    logic [7:0]           tx_data_q;
    logic [7:0]           tx_data_d;
    logic                 tx_valid_q;
    logic                 tx_valid_d;
    logic                 cmd_accept;
    logic                 mem_we;
    opcode_e              opcode;

    assign opcode     = opcode_e'(rx_data[9:8]);
    // rx_valid is a level; only its rising edge carries a new command
    assign cmd_accept = rx_valid & ~rx_valid_d_q;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;

    always_comb begin
        rx_valid_d_d = rx_valid;
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        mem_we       = 1'b0;
        if (cmd_accept) begin
            // any new command retires the previous read result; tx_data keeps its value
            tx_valid_d = 1'b0;
            unique case (opcode)
                OP_WR_ADDR: wr_addr_d = rx_data[ADDR_SIZE-1:0];
                OP_WR_DATA: begin
                    mem_we = 1'b1;
                    if (AUTO_INC) begin
                        wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
                    end
                end
                OP_RD_ADDR: rd_addr_d = rx_data[ADDR_SIZE-1:0];
                OP_RD_DATA: begin
                    tx_data_d  = mem[rd_addr_q];
                    tx_valid_d = 1'b1;
                    if (AUTO_INC) begin
                        rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_d_q <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
        end else begin
            rx_valid_d_q <= rx_valid_d_d;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
        end
    end

    // Memory is never cleared; rst_n gating suppresses a write on an edge held in reset
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem[wr_addr_q] <= rx_data[7:0];
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb/tb_spi_ram_ctrl.sv - bench for spi_ram_ctrl, AUTO_INC=0 and AUTO_INC=1 instances side by side
module tb_spi_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data0, tx_data1, wr0, wr1, rd0, rd1;
    logic       tx_valid0, tx_valid1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .wr_addr_q(wr0), .rd_addr_q(rd0)
    );

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .wr_addr_q(wr1), .rd_addr_q(rd1)
    );

    logic [7:0] o_txd [2];
    logic       o_txv [2];
    logic [7:0] o_wr  [2];
    logic [7:0] o_rd  [2];
    assign o_txd[0] = tx_data0;
    assign o_txd[1] = tx_data1;
    assign o_txv[0] = tx_valid0;
    assign o_txv[1] = tx_valid1;
    assign o_wr[0]  = wr0;
    assign o_wr[1]  = wr1;
    assign o_rd[0]  = rd0;
    assign o_rd[1]  = rd1;

    // Reference model: index 0 has no auto-increment, index 1 has it
    logic [7:0] m_mem   [2][256];
    bit         m_known [2][256];
    logic [7:0] m_wr  [2];
    logic [7:0] m_rd  [2];
    logic [7:0] m_txd [2];
    bit         m_txv [2];
    bit         m_txk [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wr[i]  = 8'h00;
            m_rd[i]  = 8'h00;
            m_txd[i] = 8'h00;
            m_txv[i] = 1'b0;
            m_txk[i] = 1'b1;
        end
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] pl);
        for (int i = 0; i < 2; i++) begin
            m_txv[i] = 1'b0;
            case (op)
                2'b00: m_wr[i] = pl;
                2'b01: begin
                    m_mem[i][m_wr[i]]   = pl;
                    m_known[i][m_wr[i]] = 1'b1;
                    if (i == 1) m_wr[i] = 8'((int'(m_wr[i]) + 1) % 256);
                end
                2'b10: m_rd[i] = pl;
                default: begin
                    m_txd[i] = m_mem[i][m_rd[i]];
                    m_txk[i] = m_known[i][m_rd[i]];
                    m_txv[i] = 1'b1;
                    if (i == 1) m_rd[i] = 8'((int'(m_rd[i]) + 1) % 256);
                end
            endcase
        end
    endtask

    // Raise rx_valid with a command; returns just after the accepting edge
    task automatic cmd_start(input logic [1:0] op, input logic [7:0] pl);
        @(negedge clk);
        rx_data  = {op, pl};
        rx_valid = 1'b1;
        @(negedge clk);
        model_cmd(op, pl);
    endtask

    task automatic cmd_finish(input int hold_left, input int idle);
        repeat (hold_left) @(negedge clk);
        rx_valid = 1'b0;
        repeat (idle) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 10'h000;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_txv[i] !== 1'b0) begin failures++; $display("FAIL reset_tx_valid[%0d] got=%b exp=0", i, o_txv[i]); end
            checks++;
            if (o_txd[i] !== 8'h00) begin failures++; $display("FAIL reset_tx_data[%0d] got=%h exp=00", i, o_txd[i]); end
            checks++;
            if (o_wr[i] !== 8'h00) begin failures++; $display("FAIL reset_wr_addr[%0d] got=%h exp=00", i, o_wr[i]); end
            checks++;
            if (o_rd[i] !== 8'h00) begin failures++; $display("FAIL reset_rd_addr[%0d] got=%h exp=00", i, o_rd[i]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_level_hold();
        cmd_start(2'b00, 8'h10);
        // payload changes while rx_valid stays high must be ignored
        rx_data = 10'h020;
        for (int c = 0; c < 11; c++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_wr[i] !== 8'h10) begin failures++; $display("FAIL hold_wr_addr[%0d] cyc=%0d got=%h exp=10", i, c, o_wr[i]); end
            end
            @(negedge clk);
        end
        cmd_finish(0, 3);
    endtask

    task automatic test_write_read();
        cmd_start(2'b00, 8'h10); cmd_finish(11, 3);
        cmd_start(2'b01, 8'hA5); cmd_finish(11, 3);
        cmd_start(2'b10, 8'h10); cmd_finish(11, 3);
        cmd_start(2'b11, 8'h00);
        for (int c = 0; c < 15; c++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_txv[i] !== 1'b1) begin failures++; $display("FAIL rd_tx_valid[%0d] cyc=%0d got=%b exp=1", i, c, o_txv[i]); end
                checks++;
                if (o_txd[i] !== 8'hA5) begin failures++; $display("FAIL rd_tx_data[%0d] cyc=%0d got=%h exp=a5", i, c, o_txd[i]); end
            end
            if (c == 10) rx_valid = 1'b0;
            @(negedge clk);
        end
        cmd_start(2'b00, 8'h20);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_txv[i] !== 1'b0) begin failures++; $display("FAIL drop_tx_valid[%0d] got=%b exp=0", i, o_txv[i]); end
            checks++;
            if (o_txd[i] !== 8'hA5) begin failures++; $display("FAIL drop_tx_data[%0d] got=%h exp=a5", i, o_txd[i]); end
            checks++;
            if (o_wr[i] !== 8'h20) begin failures++; $display("FAIL drop_wr_addr[%0d] got=%h exp=20", i, o_wr[i]); end
        end
        cmd_finish(2, 2);
    endtask

    task automatic test_autoinc_wrap();
        logic [1:0] ops [7];
        logic [7:0] pls [7];
        ops = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
        pls = '{8'hFF, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h00, 8'h10};
        for (int k = 0; k < 7; k++) begin
            cmd_start(ops[k], pls[k]);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_wr[i] !== m_wr[i]) begin failures++; $display("FAIL inc_wr_addr[%0d] step=%0d got=%h exp=%h", i, k, o_wr[i], m_wr[i]); end
                checks++;
                if (o_rd[i] !== m_rd[i]) begin failures++; $display("FAIL inc_rd_addr[%0d] step=%0d got=%h exp=%h", i, k, o_rd[i], m_rd[i]); end
                if (ops[k] == 2'b11) begin
                    checks++;
                    if (o_txd[i] !== m_txd[i] || o_txv[i] !== 1'b1) begin
                        failures++;
                        $display("FAIL inc_read[%0d] step=%0d got=%h/%b exp=%h/1", i, k, o_txd[i], o_txv[i], m_txd[i]);
                    end
                end
            end
            cmd_finish(1, 1);
        end
        checks++;
        if (m_txd[1] !== 8'h22 || o_wr[1] !== 8'h01) begin
            failures++;
            $display("FAIL inc_wrap_summary got_tx=%h got_wr=%h exp_tx=22 exp_wr=01", o_txd[1], o_wr[1]);
        end
    endtask

    task automatic test_reset_mid();
        cmd_start(2'b11, 8'h00);
        cmd_finish(1, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_txv[i] !== 1'b0 || o_wr[i] !== 8'h00 || o_rd[i] !== 8'h00 || o_txd[i] !== 8'h00) begin
                failures++;
                $display("FAIL midreset[%0d] got txv=%b txd=%h wr=%h rd=%h exp all 0", i, o_txv[i], o_txd[i], o_wr[i], o_rd[i]);
            end
        end
        rx_data  = {2'b10, 8'h10};
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_cmd(2'b10, 8'h10);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_rd[i] !== 8'h10) begin failures++; $display("FAIL release_accept_rd[%0d] got=%h exp=10", i, o_rd[i]); end
        end
        cmd_finish(2, 1);
        cmd_start(2'b11, 8'h00);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (o_txd[i] !== 8'hA5 || o_txv[i] !== 1'b1) begin
                failures++;
                $display("FAIL retained_mem[%0d] got=%h/%b exp=a5/1", i, o_txd[i], o_txv[i]);
            end
        end
        cmd_finish(1, 1);
    endtask

    task automatic test_back_to_back();
        cmd_start(2'b10, 8'h10);
        cmd_finish(1, 1);
        cmd_start(2'b11, 8'h00);
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_txv[i] !== 1'b1) begin failures++; $display("FAIL b2b_tx_valid[%0d] cyc=%0d got=%b exp=1", i, c, o_txv[i]); end
            end
            checks++;
            if (o_txd[0] !== 8'hA5) begin failures++; $display("FAIL b2b_tx_data0 cyc=%0d got=%h exp=a5", c, o_txd[0]); end
            if (c == 0) rx_valid = 1'b0;
            if (c == 1) begin rx_data = {2'b11, 8'h00}; rx_valid = 1'b1; end
            @(negedge clk);
            if (c == 1) model_cmd(2'b11, 8'h00);
        end
        cmd_finish(0, 2);
    endtask

    task automatic test_random();
        logic [1:0] op;
        logic [7:0] pl;
        for (int n = 0; n < 80; n++) begin
            op = 2'($urandom_range(0, 3));
            if (op[0] == 1'b0) pl = 8'($urandom_range(0, 7) + 252);
            else               pl = 8'($urandom);
            cmd_start(op, pl);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_wr[i] !== m_wr[i] || o_rd[i] !== m_rd[i]) begin
                    failures++;
                    $display("FAIL rand_addr[%0d] n=%0d got=%h/%h exp=%h/%h", i, n, o_wr[i], o_rd[i], m_wr[i], m_rd[i]);
                end
                checks++;
                if (o_txv[i] !== m_txv[i]) begin failures++; $display("FAIL rand_tx_valid[%0d] n=%0d got=%b exp=%b", i, n, o_txv[i], m_txv[i]); end
                if (m_txk[i]) begin
                    checks++;
                    if (o_txd[i] !== m_txd[i]) begin failures++; $display("FAIL rand_tx_data[%0d] n=%0d got=%h exp=%h", i, n, o_txd[i], m_txd[i]); end
                end
            end
            cmd_finish($urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_level_hold();
        test_write_read();
        test_autoinc_wrap();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
